// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the HI/LO multiply/divide unit.
//   WIDTH      operand width (32 only)
//   op_e       MULTU / MULT / DIVU / DIV encodings
//   state_e    sequencing states of mul_div_unit
package mips_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit_cond_neg32.sv
// cond_neg32: conditional two's-complement negate, purely combinational.
//   i_a    operand
//   i_neg  1 = output -i_a, 0 = output i_a
//   o_y    result
module cond_neg32
  import mips_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_neg ? (~i_a + {{(WIDTH-1){1'b0}}, 1'b1}) : i_a;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 MIPS HI/LO multiply/divide unit.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV when op[0]=1).
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_start, i_op[1:0], i_rs_val, i_rt_val   op launch (sampled in IDLE only)
//   i_mthi_we, i_mtlo_we, i_wdata            MTHI/MTLO (honoured when not busy)
//   o_busy, o_done, o_div_by_zero            status
//   o_hi, o_lo                               architectural HI/LO
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO accepted
// S_RUN  | 32 iterations, one result bit per clock (counter 31..0)
// S_FIX  | sign fix-up and commit to HI/LO, pulse done
module mul_div_unit
  import mips_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_mthi_we,
  input  logic             i_mtlo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_e           r_state, w_next;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_b, r_hi, r_lo;
  logic             r_is_div, r_neg_q, r_neg_r, r_dbz_pend, r_done, r_dbz;

  logic             w_accept, w_is_div, w_op_signed, w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_fix_lo, w_fix_hi, w_res_hi, w_res_lo;
  logic             w_fix_hi_neg;
  logic [WIDTH:0]   w_msum, w_dshift, w_ddiff;
  logic             w_dge;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_is_div = (i_op == OP_DIVU) || (i_op == OP_DIV);
`ifdef MULDIV_SIGNED_EN
  assign w_op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
`else
  assign w_op_signed = 1'b0;
`endif
  assign w_neg_a = w_op_signed & i_rs_val[WIDTH-1];
  assign w_neg_b = w_op_signed & i_rt_val[WIDTH-1];

  cond_neg32 u_abs_a (.i_a(i_rs_val), .i_neg(w_neg_a), .o_y(w_abs_a));
  cond_neg32 u_abs_b (.i_a(i_rt_val), .i_neg(w_neg_b), .o_y(w_abs_b));

  // Quotient/product-low negates on sign mismatch; remainder follows dividend.
  assign w_fix_hi_neg = r_is_div ? r_neg_r : r_neg_q;
  cond_neg32 u_fix_lo (.i_a(r_acc_lo), .i_neg(r_neg_q),      .o_y(w_fix_lo));
  cond_neg32 u_fix_hi (.i_a(r_acc_hi), .i_neg(w_fix_hi_neg), .o_y(w_fix_hi));

  // 64-bit negate from two 32-bit halves: the +1 carries into the high word
  // only when the low word is zero, otherwise the high word is just inverted.
  assign w_res_hi = (!r_is_div && r_neg_q && (r_acc_lo != '0)) ? ~r_acc_hi : w_fix_hi;
  assign w_res_lo = r_dbz_pend ? '1 : w_fix_lo;

  // Multiply step: multiplicand in r_b, multiplier shifts out of r_acc_lo.
  assign w_msum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
  // Divide step: 33-bit partial remainder, dividend bits shift out of r_acc_lo.
  assign w_dshift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_b};
  assign w_dge    = (w_dshift >= {1'b0, r_b});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_done        = r_done;
    o_div_by_zero = r_dbz;
    o_hi          = r_hi;
    o_lo          = r_lo;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (i_mthi_we) r_hi <= i_wdata;
          if (i_mtlo_we) r_lo <= i_wdata;
          if (w_accept) begin
            r_cnt      <= 5'd31;
            r_acc_hi   <= '0;
            r_acc_lo   <= w_abs_a;
            r_b        <= w_abs_b;
            r_is_div   <= w_is_div;
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_dbz_pend <= w_is_div && (i_rt_val == '0);
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_is_div) begin
            r_acc_hi <= w_dge ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_dge};
          end else begin
            r_acc_hi <= w_msum[WIDTH:1];
            r_acc_lo <= {w_msum[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hi  <= w_res_hi;
          r_lo  <= w_res_lo;
          r_dbz <= r_dbz_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mthi_we, mtlo_we;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  // reference HI/LO contents as the architecture should see them
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_rs_val(rs_val), .i_rt_val(rt_val),
    .i_mthi_we(mthi_we), .i_mtlo_we(mtlo_we), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_div_by_zero(dbz),
    .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Behavioural reference: MIPS HI/LO semantics in plain arithmetic.
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic sgn;
    logic [63:0] up;
    logic signed [63:0] sa, sb, sp, sq, sr;
`ifdef MULDIV_SIGNED_EN
    sgn = mop[0];
`else
    sgn = 1'b0;
`endif
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ed = 1'b0;
    if (!mop[1]) begin
      if (sgn) begin
        sp = sa * sb;
        eh = sp[63:32]; el = sp[31:0];
      end else begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32]; el = up[31:0];
      end
    end else if (b == 32'd0) begin
      ed = 1'b1; el = 32'hffff_ffff; eh = a;
    end else if (sgn) begin
      sq = sa / sb; sr = sa % sb;
      el = sq[31:0]; eh = sr[31:0];
    end else begin
      el = a / b; eh = a % b;
    end
  endfunction

  // Launch one op; optionally interfere at RUN edge inj_at, or reset at edge rst_at.
  task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int rst_at);
    logic [31:0] eh, el;
    logic ed;
    int lat;
    bit got;
    model(mop, a, b, eh, el, ed);
    @(negedge clk);
    start = 1'b1; op = mop; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    lat = 0; got = 0;
    while (lat < 40 && !got) begin
      @(negedge clk);
      start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
      op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      if (lat + 1 == inj_at) begin
        start = 1'b1; mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hdead_beef;
      end
      if (lat + 1 == rst_at) begin
        rst = 1'b1; #1;
        m_hi = '0; m_lo = '0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        chk("rst_no_done", {31'b0, done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_done_after", {31'b0, done}, 32'd0);
        chk("rst_idle", {31'b0, busy}, 32'd0);
        return;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == inj_at) begin
        chk("inj_hi_kept", hi, m_hi);
        chk("inj_lo_kept", lo, m_lo);
      end
      if (done) got = 1;
    end
    @(negedge clk); start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("latency", lat, 33);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("dbz", {31'b0, dbz}, {31'b0, ed});
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    m_hi = eh; m_lo = el;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic mov(input bit to_hi, input logic [31:0] d);
    @(negedge clk);
    mthi_we = to_hi; mtlo_we = !to_hi; wdata = d;
    @(posedge clk); #1;
    if (to_hi) m_hi = d; else m_lo = d;
    chk("mov_hi", hi, m_hi);
    chk("mov_lo", lo, m_lo);
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_dbz", {31'b0, dbz}, 32'd0);

    run_op(2'b00, 32'hffff_ffff, 32'hffff_ffff, 0, 0);
    run_op(2'b01, 32'hffff_fffd, 32'd7, 0, 0);
    run_op(2'b10, 32'd100, 32'd7, 0, 0);
    run_op(2'b11, 32'hffff_fff9, 32'd2, 0, 0);
    run_op(2'b11, 32'd5, 32'd0, 0, 0);
    run_op(2'b10, 32'd9, 32'd3, 0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hffff_ffff, 0, 0);
    mov(1'b0, 32'h0000_1234);
    run_op(2'b00, 32'd2, 32'd3, 5, 0);
    mov(1'b1, 32'h5555_aaaa);
    run_op(2'b01, 32'd123, 32'd456, 0, 10);
    run_op(2'b00, 32'd11, 32'd13, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mov(1'($urandom), $urandom);
      run_op(2'($urandom), pick(), pick(), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
